// File: rtl/vga_ctrl_pkg.sv
// vga_ctrl_pkg: 640x480@60 timing constants, counter width and RGB565 colours shared by the VGA controller.
package vga_ctrl_pkg;
    localparam int H_SYNC  = 96;
    localparam int H_BACK  = 48;
    localparam int H_VALID = 640;
    localparam int H_FRONT = 16;
    localparam int V_SYNC  = 2;
    localparam int V_BACK  = 33;
    localparam int V_VALID = 480;
    localparam int V_FRONT = 10;
    localparam int VGA_WIDTH  = H_VALID;
    localparam int VGA_HEIGHT = V_VALID;
    localparam int CNT_W = 10;
    localparam logic [CNT_W-1:0] PIX_NONE = 10'h3FF;
    localparam logic [15:0] BLACK = 16'h0000;
    localparam logic [15:0] WHITE = 16'hFFFF;
endpackage

// File: rtl/vga_ctrl_timing_cnt.sv
// vga_ctrl_timing_cnt: enabled wrap-around counter 0..MAX with terminal-count flag.
module vga_ctrl_timing_cnt #(
    parameter int MAX = 799
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_en,
    output logic [vga_ctrl_pkg::CNT_W-1:0]    o_cnt,
    output logic                              o_tc
);
    import vga_ctrl_pkg::*;

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= o_tc ? '0 : r_cnt + 1'b1;

    assign o_cnt = r_cnt;
    assign o_tc  = r_cnt == CNT_W'(MAX);
endmodule

// File: rtl/vga_ctrl.sv
// vga_ctrl: VGA raster timing generator; requests pixels one cycle ahead and
// registers the answer to rgb in step with hsync/vsync.
module vga_ctrl #(
    parameter int   H_SYNC   = vga_ctrl_pkg::H_SYNC,
    parameter int   H_BACK   = vga_ctrl_pkg::H_BACK,
    parameter int   H_VALID  = vga_ctrl_pkg::H_VALID,
    parameter int   H_FRONT  = vga_ctrl_pkg::H_FRONT,
    parameter int   V_SYNC   = vga_ctrl_pkg::V_SYNC,
    parameter int   V_BACK   = vga_ctrl_pkg::V_BACK,
    parameter int   V_VALID  = vga_ctrl_pkg::V_VALID,
    parameter int   V_FRONT  = vga_ctrl_pkg::V_FRONT,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        vga_clk,
    input  logic        sys_rst,
    input  logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_req,
    output logic        hsync,
    output logic        vsync,
    output logic [15:0] rgb,
    output logic        rgb_valid,
    output logic        frame_start,
    output logic        line_start
);
    import vga_ctrl_pkg::*;

    localparam int HA      = H_SYNC + H_BACK;
    localparam int VA      = V_SYNC + V_BACK;
    localparam int H_TOTAL = HA + H_VALID + H_FRONT;
    localparam int V_TOTAL = VA + V_VALID + V_FRONT;
    localparam logic [CNT_W-1:0] HREQ_LO = CNT_W'(HA - 1);
    localparam logic [CNT_W-1:0] HREQ_HI = CNT_W'(HA + H_VALID - 2);
    localparam logic [CNT_W-1:0] HACT_LO = CNT_W'(HA);
    localparam logic [CNT_W-1:0] HACT_HI = CNT_W'(HA + H_VALID - 1);
    localparam logic [CNT_W-1:0] VACT_LO = CNT_W'(VA);
    localparam logic [CNT_W-1:0] VACT_HI = CNT_W'(VA + V_VALID - 1);
    localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_SYNC);

    logic [CNT_W-1:0] w_h, w_v;
    logic             w_h_tc, w_unused_v_tc, w_v_act, w_act;

    vga_ctrl_timing_cnt #(.MAX(H_TOTAL - 1)) u_h_cnt (
        .i_clk(vga_clk), .i_rst(sys_rst), .i_en(1'b1), .o_cnt(w_h), .o_tc(w_h_tc)
    );

    vga_ctrl_timing_cnt #(.MAX(V_TOTAL - 1)) u_v_cnt (
        .i_clk(vga_clk), .i_rst(sys_rst), .i_en(w_h_tc), .o_cnt(w_v), .o_tc(w_unused_v_tc)
    );

    // Requests lead the active window by one column to absorb the source latency.
    assign w_v_act = (w_v >= VACT_LO) && (w_v <= VACT_HI);
    assign pix_req = (w_h >= HREQ_LO) && (w_h <= HREQ_HI) && w_v_act;
    assign pix_x   = pix_req ? w_h - HREQ_LO : PIX_NONE;
    assign pix_y   = pix_req ? w_v - VACT_LO : PIX_NONE;
    assign w_act   = (w_h >= HACT_LO) && (w_h <= HACT_HI) && w_v_act;

    always_ff @(posedge vga_clk or posedge sys_rst)
        if (sys_rst) begin
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            rgb         <= BLACK;
            rgb_valid   <= 1'b0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            hsync       <= (w_h < HS_END) ? SYNC_POL : ~SYNC_POL;
            vsync       <= (w_v < VS_END) ? SYNC_POL : ~SYNC_POL;
            rgb         <= w_act ? pix_data : BLACK;
            rgb_valid   <= w_act;
            frame_start <= (w_h == '0) && (w_v == '0);
            line_start  <= w_h == '0;
        end
endmodule

// File: tb/tb_vga_ctrl.sv
// tb_vga_ctrl: directed checks of a full-size and a small SYNC_POL=1 vga_ctrl against a cycle-index timing model.
module tb_vga_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        ff = 1'b0;
    logic [15:0] pd_a, pd_b, loop_a, loop_b;
    logic [9:0]  a_x, a_y, b_x, b_y;
    logic        a_req, a_hs, a_vs, a_rv, a_fs, a_ls;
    logic        b_req, b_hs, b_vs, b_rv, b_fs, b_ls;
    logic [15:0] a_rgb, b_rgb;

    // Loopback pixel sources with one cycle latency; X when not requested.
    always @(posedge clk) begin
        loop_a <= a_req ? {a_y[5:0], a_x} : 16'hxxxx;
        loop_b <= b_req ? {b_y[5:0], b_x} : 16'hxxxx;
    end
    assign pd_a = ff ? 16'hFFFF : loop_a;
    assign pd_b = loop_b;

    vga_ctrl dut_a (
        .vga_clk(clk), .sys_rst(rst), .pix_data(pd_a), .pix_x(a_x), .pix_y(a_y),
        .pix_req(a_req), .hsync(a_hs), .vsync(a_vs), .rgb(a_rgb), .rgb_valid(a_rv),
        .frame_start(a_fs), .line_start(a_ls)
    );

    vga_ctrl #(
        .H_SYNC(4), .H_BACK(3), .H_VALID(8), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(3), .V_VALID(4), .V_FRONT(1), .SYNC_POL(1'b1)
    ) dut_b (
        .vga_clk(clk), .sys_rst(rst), .pix_data(pd_b), .pix_x(b_x), .pix_y(b_y),
        .pix_req(b_req), .hsync(b_hs), .vsync(b_vs), .rgb(b_rgb), .rgb_valid(b_rv),
        .frame_start(b_fs), .line_start(b_ls)
    );

    typedef struct packed {
        logic        req;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        hs;
        logic        vs;
        logic        rv;
        logic [15:0] rgb;
        logic        fs;
        logic        ls;
    } exp_t;

    int n, n_checks, n_fail;
    int a_hs_lo, a_rv_cnt, a_vs_lo, b_fs_cnt, b_rv_cnt, b_vs_hi, b_hs_hi, post_fs, post_ls;
    bit post;

    // c = posedges since reset release; combinational outputs follow c, registered ones c-1.
    function automatic exp_t model(int c, int hs, int hb, int hv, int hf, int vs, int vb, int vv, int vf,
                                   logic pol, logic f);
        exp_t e;
        int ht = hs + hb + hv + hf;
        int vt = vs + vb + vv + vf;
        int ha = hs + hb;
        int va = vs + vb;
        int h  = c % ht;
        int v  = (c / ht) % vt;
        int hp = (c - 1) % ht;
        int vp = ((c - 1) / ht) % vt;
        e.req = h >= ha - 1 && h <= ha + hv - 2 && v >= va && v <= va + vv - 1;
        e.x   = e.req ? 10'(h - ha + 1) : 10'h3FF;
        e.y   = e.req ? 10'(v - va) : 10'h3FF;
        e.hs  = hp < hs ? pol : ~pol;
        e.vs  = vp < vs ? pol : ~pol;
        e.rv  = hp >= ha && hp <= ha + hv - 1 && vp >= va && vp <= va + vv - 1;
        e.rgb = !e.rv ? 16'h0000 : f ? 16'hFFFF : {6'(vp - va), 10'(hp - ha)};
        e.ls  = hp == 0;
        e.fs  = hp == 0 && vp == 0;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, n, got, exp);
        end
    endtask

    task automatic check_dut(input string p, input exp_t e, input logic req, input logic [9:0] x,
                             input logic [9:0] y, input logic hs, input logic vs, input logic rv,
                             input logic [15:0] rgb, input logic fs, input logic ls);
        check({p, "_req"}, 32'(req), 32'(e.req));
        check({p, "_x"}, 32'(x), 32'(e.x));
        check({p, "_y"}, 32'(y), 32'(e.y));
        check({p, "_hsync"}, 32'(hs), 32'(e.hs));
        check({p, "_vsync"}, 32'(vs), 32'(e.vs));
        check({p, "_rgb_valid"}, 32'(rv), 32'(e.rv));
        check({p, "_rgb"}, 32'(rgb), 32'(e.rgb));
        check({p, "_frame_start"}, 32'(fs), 32'(e.fs));
        check({p, "_line_start"}, 32'(ls), 32'(e.ls));
    endtask

    task automatic check_reset(input string p);
        exp_t ea, eb;
        ea = '{req: 1'b0, x: 10'h3FF, y: 10'h3FF, hs: 1'b1, vs: 1'b1, rv: 1'b0, rgb: 16'h0, fs: 1'b0, ls: 1'b0};
        eb = ea;
        eb.hs = 1'b0;
        eb.vs = 1'b0;
        check_dut({p, "_A"}, ea, a_req, a_x, a_y, a_hs, a_vs, a_rv, a_rgb, a_fs, a_ls);
        check_dut({p, "_B"}, eb, b_req, b_x, b_y, b_hs, b_vs, b_rv, b_rgb, b_fs, b_ls);
    endtask

    task automatic step();
        @(negedge clk);
        n++;
        check_dut("A", model(n, 96, 48, 640, 16, 2, 33, 480, 10, 1'b0, ff),
                  a_req, a_x, a_y, a_hs, a_vs, a_rv, a_rgb, a_fs, a_ls);
        check_dut("B", model(n, 4, 3, 8, 2, 2, 3, 4, 1, 1'b1, 1'b0),
                  b_req, b_x, b_y, b_hs, b_vs, b_rv, b_rgb, b_fs, b_ls);
        if (post) begin
            post_fs += int'(a_fs);
            post_ls += int'(a_ls);
        end else begin
            if (n > 35 * 800 && n <= 36 * 800) begin
                a_hs_lo  += int'(!a_hs);
                a_rv_cnt += int'(a_rv);
            end
            if (n <= 2400) a_vs_lo += int'(!a_vs);
            if (n <= 1700) begin
                b_fs_cnt += int'(b_fs);
                b_rv_cnt += int'(b_rv);
                b_vs_hi  += int'(b_vs);
                b_hs_hi  += int'(b_hs);
            end
            if (n == 35 * 800 + 142) begin
                check("win_pre_req", 32'(a_req), 32'd0);
                check("win_pre_x", 32'(a_x), 32'h3FF);
            end
            if (n == 35 * 800 + 143) begin
                check("win_rise_req", 32'(a_req), 32'd1);
                check("win_rise_x", 32'(a_x), 32'd0);
                check("win_rise_y", 32'(a_y), 32'd0);
            end
            if (n == 35 * 800 + 782) begin
                check("win_last_req", 32'(a_req), 32'd1);
                check("win_last_x", 32'(a_x), 32'd639);
            end
            if (n == 35 * 800 + 783) begin
                check("win_fall_req", 32'(a_req), 32'd0);
                check("win_fall_y", 32'(a_y), 32'h3FF);
            end
            if (n == 37 * 800) ff = 1'b1;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_reset("rst");
        rst = 1'b0;
        repeat (38 * 800 + 400) step();
        #2 rst = 1'b1;
        #1 check_reset("async_rst");
        @(negedge clk);
        @(negedge clk);
        check_reset("rst_hold");
        rst  = 1'b0;
        n    = 0;
        post = 1'b1;
        repeat (2000) step();
        check("A_hsync_low_per_line", 32'(a_hs_lo), 32'd96);
        check("A_rgb_valid_per_line", 32'(a_rv_cnt), 32'd640);
        check("A_vsync_low_clocks", 32'(a_vs_lo), 32'd1600);
        check("B_frame_starts_10_frames", 32'(b_fs_cnt), 32'd10);
        check("B_rgb_valid_10_frames", 32'(b_rv_cnt), 32'd320);
        check("B_vsync_high_10_frames", 32'(b_vs_hi), 32'd340);
        check("B_hsync_high_10_frames", 32'(b_hs_hi), 32'd400);
        check("A_post_rst_frame_starts", 32'(post_fs), 32'd1);
        check("A_post_rst_line_starts", 32'(post_ls), 32'd3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
